// File: rtl/cocc_pkg.sv
// cocc_pkg: opcodes, sequencer states and instruction field positions shared by the sequencer and ALU.
package cocc_pkg;
  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LDI  = 4'h1;
  localparam logic [3:0] OP_MOV  = 4'h2;
  localparam logic [3:0] OP_ADD  = 4'h3;
  localparam logic [3:0] OP_SUB  = 4'h4;
  localparam logic [3:0] OP_AND  = 4'h5;
  localparam logic [3:0] OP_OR   = 4'h6;
  localparam logic [3:0] OP_XOR  = 4'h7;
  localparam logic [3:0] OP_JMP  = 4'h8;
  localparam logic [3:0] OP_JZ   = 4'h9;
  localparam logic [3:0] OP_OUT  = 4'hA;
  localparam logic [3:0] OP_HALT = 4'hF;
  localparam int OP_MSB  = 15;
  localparam int OP_LSB  = 12;
  localparam int RD_MSB  = 11;
  localparam int RD_LSB  = 9;
  localparam int RS_MSB  = 8;
  localparam int RS_LSB  = 6;
  localparam int IMM_MSB = 7;
  localparam int IMM_LSB = 0;
  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, OUTW, HALT} state_t;
  function automatic logic is_alu(input logic [3:0] op);
    return op >= OP_ADD && op <= OP_XOR;
  endfunction
endpackage

// File: rtl/cocc_alu.sv
// cocc_alu: combinational ALU over the r0/r1 taps with zero detect.
module cocc_alu
  import cocc_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic [3:0]    op,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [DW-1:0] result,
  output logic          zero
);
  assign result = op == OP_ADD ? a + b :
                  op == OP_SUB ? a - b :
                  op == OP_AND ? a & b :
                  op == OP_OR  ? a | b :
                  op == OP_XOR ? a ^ b : '0;
  assign zero = result == '0;
endmodule

// File: rtl/regfile_sequencer.sv
// regfile_sequencer: fetch/decode/exec sequencer driving the register file ports and a valid/ready output.
module regfile_sequencer
  import cocc_pkg::*;
#(
  parameter int PC_W = 8,
  parameter int DW   = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            run,
  output logic [PC_W-1:0] imem_addr,
  input  logic [15:0]     imem_rdata,
  output logic            rf_we,
  output logic [2:0]      rf_iaddr,
  output logic [DW-1:0]   rf_idata,
  output logic [2:0]      rf_oaddr,
  output logic            rf_oe,
  input  logic [DW-1:0]   rf_odata,
  input  logic [DW-1:0]   rf_rega,
  input  logic [DW-1:0]   rf_regb,
  output logic [DW-1:0]   out_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            zero,
  output logic            halted
);
  state_t          state, state_n;
  logic [PC_W-1:0] pc;
  logic [15:0]     ir;
  logic            z;
  logic [3:0]      op;
  logic [2:0]      rd, rs;
  logic [DW-1:0]   imm;
  logic [DW-1:0]   alu_res;
  logic            alu_zero;
  logic            in_exec;
  assign op        = ir[OP_MSB:OP_LSB];
  assign rd        = ir[RD_MSB:RD_LSB];
  assign rs        = ir[RS_MSB:RS_LSB];
  assign imm       = DW'(ir[IMM_MSB:IMM_LSB]);
  assign imem_addr = pc;
  assign zero      = z;
  assign halted    = state == HALT;
  // reset must suppress a write issued in the same cycle, so gate combinationally
  assign in_exec   = state == EXEC && !rst;
  cocc_alu #(.DW(DW)) u_alu (
    .op     (op),
    .a      (rf_rega),
    .b      (rf_regb),
    .result (alu_res),
    .zero   (alu_zero)
  );
  always_comb begin
    rf_we    = in_exec && (is_alu(op) || op == OP_LDI || op == OP_MOV);
    rf_oe    = in_exec && (op == OP_MOV || op == OP_OUT);
    rf_iaddr = rf_we ? rd : '0;
    rf_oaddr = rf_oe ? rs : '0;
    rf_idata = !rf_we ? '0 : op == OP_LDI ? imm : op == OP_MOV ? rf_odata : alu_res;
    state_n  = state;
    unique case (state)
      IDLE:    state_n = run ? FETCH : IDLE;
      FETCH:   state_n = DECODE;
      DECODE:  state_n = EXEC;
      EXEC:    state_n = op == OP_OUT ? OUTW : op == OP_HALT ? HALT : FETCH;
      OUTW:    state_n = out_ready ? FETCH : OUTW;
      HALT:    state_n = HALT;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      pc        <= '0;
      ir        <= '0;
      z         <= 1'b0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      state <= state_n;
      if (state == DECODE) begin
        ir <= imem_rdata;
        pc <= pc + 1'b1;
      end
      if (state == EXEC) begin
        if (is_alu(op)) z <= alu_zero;
        if (op == OP_JMP || (op == OP_JZ && z)) pc <= PC_W'(ir[IMM_MSB:IMM_LSB]);
        if (op == OP_OUT) begin
          out_data  <= rf_odata;
          out_valid <= 1'b1;
        end
      end
      if (state == OUTW && out_ready) out_valid <= 1'b0;
    end
  end
endmodule
